// File: rtl/branch_meta_pipe_pkg.sv
// ---------------------------------------------------------------------------
// branch_meta_pipe_pkg
//   Shared types and helpers for the branch metadata pipeline.
//   - branch_meta_t : one in-flight record (IF/ID, ID/EX and EX/MEM share it;
//                     fields a stage does not use yet simply ride along).
//   - pc_index      : PC word-index field, PC[width+1:2], zero-extended to 32.
//   - pc_tag        : PC bits above an index field, PC[31:index_width+2].
// ---------------------------------------------------------------------------
package branch_meta_pipe_pkg;

    localparam int unsigned PC_W      = 32;
    // The record carries the GHR snapshot at a fixed maximum width; only the
    // low GHR_WIDTH bits are ever non-zero.
    localparam int unsigned GHR_MAX_W = 32;

    typedef struct packed {
        logic                 valid;
        logic [PC_W-1:0]      pc;
        logic                 btb_hit;
        logic                 prediction;
        logic [GHR_MAX_W-1:0] ghr;
        logic                 is_jmp;
        logic                 decision;
        logic [PC_W-1:0]      target;
    } branch_meta_t;

    // PC[width+1:2], right-aligned.
    function automatic logic [PC_W-1:0] pc_index(input logic [PC_W-1:0] pc,
                                                 input int unsigned     width);
        logic [PC_W-1:0] mask;
        mask = (PC_W'(1) << width) - PC_W'(1);
        return (pc >> 2) & mask;
    endfunction

    // PC[31:index_width+2], right-aligned.
    function automatic logic [PC_W-1:0] pc_tag(input logic [PC_W-1:0] pc,
                                               input int unsigned     index_width);
        return pc >> (index_width + 2);
    endfunction

endpackage

// File: rtl/branch_meta_pipe_ghr_unit.sv
// ---------------------------------------------------------------------------
// branch_meta_pipe_ghr_unit
//   Gshare global history: a speculative copy updated from IF predictions and
//   a committed copy updated from resolved branches at MEM. A repair reloads
//   the speculative copy with the committed history plus the decision being
//   committed on the same edge.
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   spec_en      shift spec_bit into the speculative history
//   spec_bit     IF prediction
//   repair       mispredict flush; overrides spec_en
//   commit_en    a valid branch commits at MEM this edge
//   commit_bit   its resolved decision (0 when nothing commits)
//   spec_ghr     speculative history
// ---------------------------------------------------------------------------
module branch_meta_pipe_ghr_unit #(
    parameter int unsigned GHR_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 spec_en,
    input  logic                 spec_bit,
    input  logic                 repair,
    input  logic                 commit_en,
    input  logic                 commit_bit,
    output logic [GHR_WIDTH-1:0] spec_ghr
);

    logic [GHR_WIDTH-1:0] spec_q;
    logic [GHR_WIDTH-1:0] commit_q;
    logic [GHR_WIDTH-1:0] spec_shift;
    logic [GHR_WIDTH-1:0] commit_shift;

    // Concatenate then truncate so a 1-bit history needs no special case.
    assign spec_shift   = GHR_WIDTH'({spec_q,   spec_bit});
    assign commit_shift = GHR_WIDTH'({commit_q, commit_bit});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spec_q   <= '0;
            commit_q <= '0;
        end else begin
            if (commit_en)
                commit_q <= commit_shift;
            // Repair uses the history as it will look after this edge's commit.
            if (repair)
                spec_q <= commit_shift;
            else if (spec_en)
                spec_q <= spec_shift;
        end
    end

    assign spec_ghr = spec_q;

endmodule

// File: rtl/branch_meta_pipe.sv
// ---------------------------------------------------------------------------
// branch_meta_pipe
//   Carries branch-prediction metadata IF -> ID -> EX -> MEM and produces the
//   predictor's IF read indexes and MEM-stage update inputs. Holds the gshare
//   history (speculative and committed) and branch / mispredict counters.
// Ports
//   clk_i, rst_ni            clock, synchronous active-low reset
//   IF_PC_i, IF_btb_hit_i,   Fetch PC and the predictor's answer for it
//   IF_prediction_i
//   IF_btb_rd_index_o,       combinational BTB index / tag of IF_PC_i
//   IF_PC_tag_o
//   IF_pht_rd_index_o        combinational PHT index (PC bits ^ spec GHR)
//   stall_i                  hold IF/ID, bubble into ID/EX
//   flush_i                  mispredict flush, clears all in-flight records
//   ID_is_jmp_i              decoder branch/jump flag for the ID record
//   EX_br_decision_i,        EX-resolved outcome for the EX record
//   EX_br_target_i
//   EXMEM_*                  predictor update fields for the MEM record
//   br_count_o,              committed branch / mispredict counters (wrap)
//   mispred_count_o
// ---------------------------------------------------------------------------
module branch_meta_pipe
    import branch_meta_pipe_pkg::*;
#(
    parameter int unsigned PHT_INDEX_WIDTH = 8,
    parameter int unsigned BTB_INDEX_WIDTH = 6,
    parameter int unsigned GHR_WIDTH       = 8,
    parameter int unsigned CNT_WIDTH       = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [31:0]                  IF_PC_i,
    input  logic                         IF_btb_hit_i,
    input  logic                         IF_prediction_i,
    output logic [BTB_INDEX_WIDTH-1:0]   IF_btb_rd_index_o,
    output logic [29-BTB_INDEX_WIDTH:0]  IF_PC_tag_o,
    output logic [PHT_INDEX_WIDTH-1:0]   IF_pht_rd_index_o,
    input  logic                         stall_i,
    input  logic                         flush_i,
    input  logic                         ID_is_jmp_i,
    input  logic                         EX_br_decision_i,
    input  logic [31:0]                  EX_br_target_i,
    output logic [BTB_INDEX_WIDTH-1:0]   EXMEM_btb_wr_index_o,
    output logic [29-BTB_INDEX_WIDTH:0]  EXMEM_btb_wr_tag_o,
    output logic [PHT_INDEX_WIDTH-1:0]   EXMEM_pht_wr_index_o,
    output logic [31:0]                  EXMEM_btb_wr_target_o,
    output logic                         EXMEM_btb_hit_o,
    output logic                         EXMEM_is_jmp_o,
    output logic                         EXMEM_br_decision_o,
    output logic                         EXMEM_prediction_o,
    output logic [31:0]                  EXMEM_PCplus4_o,
    output logic [CNT_WIDTH-1:0]         br_count_o,
    output logic [CNT_WIDTH-1:0]         mispred_count_o
);

    localparam int unsigned TAG_W = 30 - BTB_INDEX_WIDTH;

    logic [GHR_WIDTH-1:0] spec_ghr;

    branch_meta_t if_rec;
    branch_meta_t if_id_q;
    branch_meta_t id_ex_q;
    branch_meta_t ex_mem_q;
    branch_meta_t id_next;
    branch_meta_t ex_next;

    logic [CNT_WIDTH-1:0] br_cnt_q;
    logic [CNT_WIDTH-1:0] mispred_cnt_q;

    logic commit_en;
    logic mem_decision;
    logic mispredict;

    // ---------------------------------------------------------------- commit
    assign commit_en    = ex_mem_q.valid & ex_mem_q.is_jmp;
    assign mem_decision = commit_en & ex_mem_q.decision;
    assign mispredict   = commit_en & (ex_mem_q.prediction ^ ex_mem_q.decision);

    // ---------------------------------------------------------------- history
    branch_meta_pipe_ghr_unit #(
        .GHR_WIDTH (GHR_WIDTH)
    ) u_ghr (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .spec_en    (IF_btb_hit_i & ~stall_i),
        .spec_bit   (IF_prediction_i),
        .repair     (flush_i),
        .commit_en  (commit_en),
        .commit_bit (mem_decision),
        .spec_ghr   (spec_ghr)
    );

    // ---------------------------------------------------------------- IF side
    assign IF_btb_rd_index_o = BTB_INDEX_WIDTH'(pc_index(IF_PC_i, BTB_INDEX_WIDTH));
    assign IF_PC_tag_o       = TAG_W'(pc_tag(IF_PC_i, BTB_INDEX_WIDTH));
    assign IF_pht_rd_index_o = PHT_INDEX_WIDTH'(pc_index(IF_PC_i, PHT_INDEX_WIDTH))
                             ^ PHT_INDEX_WIDTH'(spec_ghr);

    // The snapshot is the history used for this fetch's PHT read, so the
    // MEM-stage write lands on the same counter.
    always_comb begin
        if_rec            = '0;
        if_rec.valid      = 1'b1;
        if_rec.pc         = IF_PC_i;
        if_rec.btb_hit    = IF_btb_hit_i;
        if_rec.prediction = IF_prediction_i;
        if_rec.ghr        = GHR_MAX_W'(spec_ghr);
    end

    always_comb begin
        id_next        = if_id_q;
        id_next.is_jmp = ID_is_jmp_i;
    end

    always_comb begin
        ex_next          = id_ex_q;
        ex_next.decision = EX_br_decision_i;
        ex_next.target   = EX_br_target_i;
    end

    // ---------------------------------------------------------------- records
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            if_id_q       <= '0;
            id_ex_q       <= '0;
            ex_mem_q      <= '0;
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            // The MEM record commits even on a flush edge.
            if (commit_en)
                br_cnt_q <= br_cnt_q + CNT_WIDTH'(1);
            if (mispredict)
                mispred_cnt_q <= mispred_cnt_q + CNT_WIDTH'(1);

            if (flush_i) begin
                if_id_q.valid  <= 1'b0;
                id_ex_q.valid  <= 1'b0;
                ex_mem_q.valid <= 1'b0;
            end else begin
                ex_mem_q <= ex_next;
                if (stall_i) begin
                    id_ex_q <= '0;          // bubble; IF/ID keeps its record
                end else begin
                    id_ex_q <= id_next;
                    if_id_q <= if_rec;
                end
            end
        end
    end

    // ---------------------------------------------------------------- MEM side
    assign EXMEM_btb_wr_index_o  = BTB_INDEX_WIDTH'(pc_index(ex_mem_q.pc, BTB_INDEX_WIDTH));
    assign EXMEM_btb_wr_tag_o    = TAG_W'(pc_tag(ex_mem_q.pc, BTB_INDEX_WIDTH));
    assign EXMEM_pht_wr_index_o  = PHT_INDEX_WIDTH'(pc_index(ex_mem_q.pc, PHT_INDEX_WIDTH))
                                 ^ PHT_INDEX_WIDTH'(ex_mem_q.ghr);
    assign EXMEM_btb_wr_target_o = ex_mem_q.target;

    // Controls are gated so an empty slot never looks like a branch.
    assign EXMEM_btb_hit_o     = ex_mem_q.valid & ex_mem_q.btb_hit;
    assign EXMEM_is_jmp_o      = commit_en;
    assign EXMEM_br_decision_o = mem_decision;
    assign EXMEM_prediction_o  = ex_mem_q.valid & ex_mem_q.prediction;
    // Gated too, so an empty slot reads as all-zero rather than 4.
    assign EXMEM_PCplus4_o     = ex_mem_q.valid ? (ex_mem_q.pc + 32'd4) : 32'd0;

    assign br_count_o      = br_cnt_q;
    assign mispred_count_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_meta_pipe.sv
module tb_branch_meta_pipe;

    localparam int CW = 4;

    logic        clk;
    logic        rst_n, hit, pred, stall, flush, jmp, dec;
    logic [31:0] pc, tgt;

    logic [5:0]    if_btb_idx, wr_btb_idx;
    logic [23:0]   if_tag, wr_tag;
    logic [7:0]    if_pht_idx, wr_pht_idx;
    logic [31:0]   wr_target, pcplus4;
    logic          o_hit, o_jmp, o_dec, o_pred;
    logic [CW-1:0] br_cnt, mis_cnt;

    int checks = 0;
    int errors = 0;

    branch_meta_pipe #(
        .PHT_INDEX_WIDTH(8), .BTB_INDEX_WIDTH(6), .GHR_WIDTH(8), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .IF_PC_i(pc), .IF_btb_hit_i(hit), .IF_prediction_i(pred),
        .IF_btb_rd_index_o(if_btb_idx), .IF_PC_tag_o(if_tag), .IF_pht_rd_index_o(if_pht_idx),
        .stall_i(stall), .flush_i(flush), .ID_is_jmp_i(jmp),
        .EX_br_decision_i(dec), .EX_br_target_i(tgt),
        .EXMEM_btb_wr_index_o(wr_btb_idx), .EXMEM_btb_wr_tag_o(wr_tag),
        .EXMEM_pht_wr_index_o(wr_pht_idx), .EXMEM_btb_wr_target_o(wr_target),
        .EXMEM_btb_hit_o(o_hit), .EXMEM_is_jmp_o(o_jmp), .EXMEM_br_decision_o(o_dec),
        .EXMEM_prediction_o(o_pred), .EXMEM_PCplus4_o(pcplus4),
        .br_count_o(br_cnt), .mispred_count_o(mis_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model: one slot per pipeline position
    typedef struct {
        bit        v;
        bit [31:0] pc;
        bit        hit;
        bit        pred;
        bit [31:0] ghr;
        bit        j;
        bit        d;
        bit [31:0] tgt;
    } slot_t;

    slot_t       s [3];   // 0: IF/ID, 1: ID/EX, 2: EX/MEM
    int unsigned sghr, cghr, brc, mis;

    task automatic model_edge();
        bit          commit;
        bit          gd;
        int unsigned hist_after;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) s[i] = '{default: 0};
            sghr = 0; cghr = 0; brc = 0; mis = 0;
            return;
        end
        commit     = s[2].v && s[2].j;
        gd         = commit && s[2].d;
        hist_after = ((cghr << 1) | gd) & 32'hFF;
        if (commit) begin
            brc++;
            if (s[2].pred != s[2].d) mis++;
        end
        if (flush) begin
            sghr = hist_after;
            for (int i = 0; i < 3; i++) s[i].v = 0;
        end else begin
            s[2]     = s[1];
            s[2].d   = dec;
            s[2].tgt = tgt;
            if (stall) begin
                s[1].v = 0;
            end else begin
                s[1]   = s[0];
                s[1].j = jmp;
                s[0]   = '{v: 1, pc: pc, hit: hit, pred: pred, ghr: sghr, j: 0, d: 0, tgt: 0};
                if (hit) sghr = ((sghr << 1) | pred) & 32'hFF;
            end
        end
        if (commit) cghr = hist_after;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        bit v;
        bit j;
        v = s[2].v;
        j = v && s[2].j;
        chk("if_btb_rd_index", 32'(if_btb_idx), (pc >> 2) & 32'h3F);
        chk("if_pc_tag",       32'(if_tag),     pc >> 8);
        chk("if_pht_rd_index", 32'(if_pht_idx), ((pc >> 2) ^ sghr) & 32'hFF);
        chk("exmem_btb_hit",   32'(o_hit),  32'(v && s[2].hit));
        chk("exmem_is_jmp",    32'(o_jmp),  32'(j));
        chk("exmem_decision",  32'(o_dec),  32'(j && s[2].d));
        chk("exmem_pred",      32'(o_pred), 32'(v && s[2].pred));
        chk("exmem_pcplus4",   pcplus4,     v ? s[2].pc + 32'd4 : 32'd0);
        if (v) begin
            chk("exmem_btb_wr_index", 32'(wr_btb_idx), (s[2].pc >> 2) & 32'h3F);
            chk("exmem_btb_wr_tag",   32'(wr_tag),     s[2].pc >> 8);
            chk("exmem_pht_wr_index", 32'(wr_pht_idx), ((s[2].pc >> 2) ^ s[2].ghr) & 32'hFF);
            chk("exmem_target",       wr_target,       s[2].tgt);
        end
        chk("br_count",      32'(br_cnt),  brc % (1 << CW));
        chk("mispred_count", 32'(mis_cnt), mis % (1 << CW));
    endtask

    // One clock: model follows the edge, outputs are compared mid-cycle.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic r, input logic [31:0] p, input logic h, input logic pr,
                         input logic st, input logic fl, input logic jm, input logic d);
        rst_n = r; pc = p; hit = h; pred = pr; stall = st; flush = fl; jmp = jm; dec = d;
        tgt = p ^ 32'h5A5A_0000;
    endtask

    bit p3 [4] = '{1, 0, 1, 1};
    bit d3 [4] = '{1, 0, 1, 0};

    initial begin
        for (int i = 0; i < 3; i++) s[i] = '{default: 0};
        sghr = 0; cghr = 0; brc = 0; mis = 0;

        // ---- reset state
        drive(0, 32'h0000_03FC, 1, 1, 0, 0, 1, 1);
        tick(); tick();
        chk("rst_is_jmp",   32'(o_jmp), 0);
        chk("rst_pcplus4",  pcplus4, 0);
        chk("rst_wr_index", 32'(wr_btb_idx), 0);
        chk("rst_pht_wr",   32'(wr_pht_idx), 0);
        chk("rst_target",   wr_target, 0);
        chk("rst_br_count", 32'(br_cnt), 0);
        chk("rst_pht_rd",   32'(if_pht_idx), 32'hFF);

        // ---- single predicted-taken BTB hit
        drive(1, 32'h0000_0100, 1, 1, 0, 0, 0, 0);
        #1 chk("lit_pht_rd_0x100", 32'(if_pht_idx), 32'h40);
        tick();
        drive(1, 32'h0, 0, 0, 0, 0, 0, 0);
        #1 chk("lit_spec_ghr_01", 32'(if_pht_idx), 32'h01);
        tick(); tick();
        chk("lit_pht_wr",   32'(wr_pht_idx), 32'h40);
        chk("lit_btb_wr",   32'(wr_btb_idx), 32'h00);
        chk("lit_tag_wr",   32'(wr_tag),     32'h1);
        chk("lit_pcplus4",  pcplus4,         32'h104);

        // ---- commit history 101, then a mispredicted branch with flush
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        for (int c = 0; c < 7; c++) begin
            drive(1, 32'h1000 + 32'(4 * c), 0, (c < 4) ? p3[c] : 1'b0, 0, (c == 6), 1,
                  (c >= 2 && c < 6) ? d3[c-2] : 1'b0);
            tick();
        end
        drive(1, 32'h0, 0, 0, 0, 0, 1, 1);
        #1;
        chk("lit_repair_ghr_0A", 32'(if_pht_idx), 32'h0A);
        chk("lit_flush_mispred", 32'(mis_cnt), 1);
        chk("lit_flush_br",      32'(br_cnt), 4);
        chk("lit_flush_invalid", 32'(o_jmp), 0);

        // ---- stall for two cycles
        tick(); tick();
        drive(1, 32'h2000, 0, 0, 0, 0, 1, 1);
        tick();
        drive(1, 32'h3000, 1, 1, 1, 0, 1, 1);
        tick();
        chk("lit_stall_drain1", 32'(o_jmp), 1);
        drive(1, 32'h0, 1, 1, 1, 0, 1, 1);
        tick();
        chk("lit_stall_drain2", 32'(o_jmp), 0);
        chk("lit_stall_ghr",    32'(if_pht_idx), 32'h0A);
        drive(1, 32'h4000, 0, 0, 0, 0, 1, 1);
        tick(); tick();
        chk("lit_stall_held_pc", pcplus4, 32'h2004);

        // ---- stall and flush together: flush wins
        drive(1, 32'h5000, 0, 0, 1, 1, 1, 1);
        tick();
        chk("lit_sf_exmem", 32'(o_jmp), 0);
        drive(1, 32'h6000, 0, 0, 0, 0, 1, 1);
        tick(); tick();
        chk("lit_sf_ifid_invalid", 32'(o_jmp), 0);
        tick();
        chk("lit_sf_refill", 32'(o_jmp), 1);

        // ---- counter wrap: 16 branches, 3 mispredicts
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        for (int c = 0; c < 19; c++) begin
            drive(1, 32'h8000 + 32'(4 * c), 0, 1, 0, 0, 1,
                  (c == 4 || c == 9 || c == 13) ? 1'b0 : 1'b1);
            tick();
            if (c == 17) chk("lit_br_15", 32'(br_cnt), 15);
        end
        chk("lit_br_wrap",   32'(br_cnt),  0);
        chk("lit_mis_three", 32'(mis_cnt), 3);

        // ---- randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom(),
                  1'($urandom()), 1'($urandom()),
                  ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 8),
                  1'($urandom()), 1'($urandom()));
            tgt = $urandom();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
